// File: rtl/letc_core_limp_arbiter.sv
// letc_core_limp_arbiter: N-way LIMP requester arbiter onto one AXI FSM port.
// Registered grants held for the whole transaction, back-to-back on completion.
module letc_core_limp_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_wen_nren,
  input  logic [2*NUM_REQ-1:0]      i_req_size,
  input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_req_rdata,
  output logic                      o_sub_valid,
  output logic                      o_sub_wen_nren,
  output logic [1:0]                o_sub_size,
  output logic [ADDR_W-1:0]         o_sub_addr,
  output logic [DATA_W-1:0]         o_sub_wdata,
  input  logic                      i_sub_ready,
  input  logic [DATA_W-1:0]         i_sub_rdata,
  output logic                      o_busy,
  output logic [IDX_W-1:0]          o_grant_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   rr_nxt;
  logic               found;
  logic [NUM_REQ-1:0] cand;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     sum;
  logic [IDX_W:0]     nxt;

  // Candidates: the current grant is masked while it completes
  always_comb begin
    cand = i_req_valid;
    if (state_q == BUSY)
      cand = i_req_valid & ~(NUM_REQ'(1) << grant_q);
  end

  // Rotating search from start; start is 0 for fixed priority
  always_comb begin
    start  = (ARB_MODE == 1) ? rr_q : '0;
    dbl    = {cand, cand} >> start;
    rot    = dbl[NUM_REQ-1:0];
    found  = 1'b0;
    win    = '0;
    sum    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, start} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ))
        sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!found && rot[i]) begin
        found = 1'b1;
        win   = sum[IDX_W-1:0];
      end
    end
    nxt = {1'b0, win} + (IDX_W+1)'(1);
    if (nxt >= (IDX_W+1)'(NUM_REQ))
      nxt = '0;
    rr_nxt = nxt[IDX_W-1:0];
  end

  // Next state: grant on request in IDLE, re-arbitrate on completion in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = win;
          rr_d    = rr_nxt;
        end
      end
      BUSY: begin
        if (i_sub_ready) begin
          if (found) begin
            grant_d = win;
            rr_d    = rr_nxt;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Live mux of the granted requester and ready steering
  always_comb begin
    o_sub_wen_nren = i_req_wen_nren[0];
    o_sub_size     = i_req_size[1:0];
    o_sub_addr     = i_req_addr[ADDR_W-1:0];
    o_sub_wdata    = i_req_wdata[DATA_W-1:0];
    o_req_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        o_sub_wen_nren = i_req_wen_nren[i];
        o_sub_size     = i_req_size[2*i +: 2];
        o_sub_addr     = i_req_addr[ADDR_W*i +: ADDR_W];
        o_sub_wdata    = i_req_wdata[DATA_W*i +: DATA_W];
        o_req_ready[i] = (state_q == BUSY) && i_sub_ready;
      end
    end
  end

  assign o_sub_valid = (state_q == BUSY);
  assign o_busy      = (state_q == BUSY);
  assign o_grant_idx = grant_q;
  assign o_req_rdata = i_sub_rdata;

  // Granted requester must hold valid until it sees ready
  a_hold_valid: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (state_q == BUSY) |-> i_req_valid[grant_q]
  );

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// tb_letc_core_limp_arbiter: directed checks of the LIMP arbiter.
// Instance a: 3 requesters fixed priority; instance b: 4 requesters round-robin.
module tb_letc_core_limp_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0]   a_valid, a_wen, a_ready;
  logic [5:0]   a_size;
  logic [95:0]  a_addr, a_wdata;
  logic [31:0]  a_rdata, a_sub_addr, a_sub_wdata, a_sub_rdata;
  logic         a_sub_valid, a_sub_wen, a_sub_ready, a_busy;
  logic [1:0]   a_sub_size, a_gidx;

  logic [3:0]   b_valid, b_wen, b_ready;
  logic [7:0]   b_size;
  logic [127:0] b_addr, b_wdata;
  logic [31:0]  b_rdata, b_sub_addr, b_sub_wdata, b_sub_rdata;
  logic         b_sub_valid, b_sub_wen, b_sub_ready, b_busy;
  logic [1:0]   b_sub_size, b_gidx;

  int cnt [4];

  letc_core_limp_arbiter #(
    .NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(a_valid), .i_req_wen_nren(a_wen),
    .i_req_size(a_size), .i_req_addr(a_addr),
    .i_req_wdata(a_wdata), .o_req_ready(a_ready),
    .o_req_rdata(a_rdata), .o_sub_valid(a_sub_valid),
    .o_sub_wen_nren(a_sub_wen), .o_sub_size(a_sub_size),
    .o_sub_addr(a_sub_addr), .o_sub_wdata(a_sub_wdata),
    .i_sub_ready(a_sub_ready), .i_sub_rdata(a_sub_rdata),
    .o_busy(a_busy), .o_grant_idx(a_gidx)
  );

  letc_core_limp_arbiter #(
    .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(b_valid), .i_req_wen_nren(b_wen),
    .i_req_size(b_size), .i_req_addr(b_addr),
    .i_req_wdata(b_wdata), .o_req_ready(b_ready),
    .o_req_rdata(b_rdata), .o_sub_valid(b_sub_valid),
    .o_sub_wen_nren(b_sub_wen), .o_sub_size(b_sub_size),
    .o_sub_addr(b_sub_addr), .o_sub_wdata(b_sub_wdata),
    .i_sub_ready(b_sub_ready), .i_sub_rdata(b_sub_rdata),
    .o_busy(b_busy), .o_grant_idx(b_gidx)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = '0; a_wen = '0; a_size = '0; a_addr = '0; a_wdata = '0;
    a_sub_ready = 1'b0; a_sub_rdata = '0;
    b_valid = '0; b_wen = '0; b_size = '0; b_addr = '0; b_wdata = '0;
    b_sub_ready = 1'b0; b_sub_rdata = '0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;

    step(); step(); #1;
    chk("rst_a_valid", 64'(a_sub_valid), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_a_gidx", 64'(a_gidx), 64'd0);
    chk("rst_b_valid", 64'(b_sub_valid), 64'd0);
    chk("rst_b_gidx", 64'(b_gidx), 64'd0);
    step();
    rst_n = 1'b1;

    // simple read by req 2
    step();
    a_valid = 3'b100;
    a_size[5:4] = 2'b10;
    a_addr[64 +: 32] = 32'h8000_0010;
    a_addr[0 +: 32] = 32'h0000_0100;
    #1 chk("rd_idle_valid", 64'(a_sub_valid), 64'd0);
    step(); #1;
    chk("rd_valid", 64'(a_sub_valid), 64'd1);
    chk("rd_addr", 64'(a_sub_addr), 64'h8000_0010);
    chk("rd_wen", 64'(a_sub_wen), 64'd0);
    chk("rd_gidx", 64'(a_gidx), 64'd2);
    chk("rd_busy", 64'(a_busy), 64'd1);
    chk("rd_ready0", 64'(a_ready), 64'd0);
    step(); #1 chk("rd_ready1", 64'(a_ready), 64'd0);
    step(); #1 chk("rd_ready2", 64'(a_ready), 64'd0);
    step();
    a_sub_ready = 1'b1;
    a_sub_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_ready", 64'(a_ready), 64'b100);
    chk("rd_rdata", 64'(a_rdata), 64'hDEAD_BEEF);
    step();
    a_sub_ready = 1'b0;
    a_valid = 3'b000;
    #1;
    chk("rd_done_valid", 64'(a_sub_valid), 64'd0);
    chk("rd_done_ready", 64'(a_ready), 64'd0);
    chk("rd_done_busy", 64'(a_busy), 64'd0);
    chk("rd_done_gidx", 64'(a_gidx), 64'd2);

    // fixed priority, no preemption
    step();
    a_valid = 3'b100;
    step();
    a_valid = 3'b101;
    #1 chk("fp_gidx_a", 64'(a_gidx), 64'd2);
    step(); #1;
    chk("fp_gidx_b", 64'(a_gidx), 64'd2);
    chk("fp_addr_b", 64'(a_sub_addr), 64'h8000_0010);
    a_sub_ready = 1'b1;
    #1 chk("fp_ready2", 64'(a_ready), 64'b100);
    step();
    a_valid = 3'b001;
    #1;
    chk("fp_b2b_valid", 64'(a_sub_valid), 64'd1);
    chk("fp_b2b_gidx", 64'(a_gidx), 64'd0);
    chk("fp_b2b_addr", 64'(a_sub_addr), 64'h0000_0100);
    chk("fp_ready0", 64'(a_ready), 64'b001);
    step();
    a_valid = 3'b000;
    a_sub_ready = 1'b0;
    #1 chk("fp_idle", 64'(a_busy), 64'd0);

    // reset mid-transaction
    step();
    a_valid = 3'b010;
    a_addr[32 +: 32] = 32'h0000_0200;
    step(); #1;
    chk("mr_gidx", 64'(a_gidx), 64'd1);
    chk("mr_busy", 64'(a_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", 64'(a_sub_valid), 64'd0);
    chk("mr_rst_busy", 64'(a_busy), 64'd0);
    chk("mr_rst_gidx", 64'(a_gidx), 64'd0);
    chk("mr_rst_ready", 64'(a_ready), 64'd0);
    step();
    rst_n = 1'b1;
    #1 chk("mr_rel_valid", 64'(a_sub_valid), 64'd0);
    step(); #1;
    chk("mr_regrant", 64'(a_sub_valid), 64'd1);
    chk("mr_regidx", 64'(a_gidx), 64'd1);
    a_sub_ready = 1'b1;
    step();
    a_sub_ready = 1'b0;
    a_valid = 3'b000;

    // round-robin fairness on b with requesters 0..2
    b_valid = 4'b0111;
    b_size = 8'b1010_1010;
    step();
    for (int t = 0; t < 6; t++) begin
      b_sub_ready = 1'b1;
      #1;
      chk("rr_valid", 64'(b_sub_valid), 64'd1);
      chk("rr_gidx", 64'(b_gidx), 64'(t % 3));
      chk("rr_ready", 64'(b_ready), 64'(4'b0001 << (t % 3)));
      cnt[b_gidx]++;
      if (t == 5) b_valid = 4'b0100;
      step();
    end
    b_sub_ready = 1'b0;
    b_valid = 4'b0000;
    #1 chk("rr_idle", 64'(b_busy), 64'd0);
    for (int i = 0; i < 3; i++) chk("rr_count", 64'(cnt[i]), 64'd2);

    // wrap from rr_ptr = 3
    b_valid = 4'b0011;
    step(); #1;
    chk("wr_gidx0", 64'(b_gidx), 64'd0);
    b_valid = 4'b0001;
    b_sub_ready = 1'b1;
    step();
    b_sub_ready = 1'b0;
    b_valid = 4'b0011;
    #1 chk("wr_idle", 64'(b_busy), 64'd0);
    step(); #1;
    chk("wr_gidx1", 64'(b_gidx), 64'd1);
    b_valid = 4'b0010;
    b_sub_ready = 1'b1;
    step();
    b_sub_ready = 1'b0;
    b_valid = 4'b0000;

    // packed write from req 3 with concurrent req 1
    b_wen = 4'b1000;
    b_size = 8'b0100_1000;
    b_addr[96 +: 32] = 32'h0000_0F02;
    b_wdata[96 +: 32] = 32'h1234_5678;
    b_addr[32 +: 32] = 32'h0000_0300;
    b_valid = 4'b1010;
    step(); #1;
    chk("wt_gidx", 64'(b_gidx), 64'd3);
    chk("wt_wen", 64'(b_sub_wen), 64'd1);
    chk("wt_size", 64'(b_sub_size), 64'b01);
    chk("wt_addr", 64'(b_sub_addr), 64'h0000_0F02);
    chk("wt_wdata", 64'(b_sub_wdata), 64'h1234_5678);
    step(); #1;
    chk("wt_hold", 64'(b_gidx), 64'd3);
    b_sub_ready = 1'b1;
    #1 chk("wt_ready", 64'(b_ready), 64'b1000);
    step();
    b_valid = 4'b0010;
    b_sub_ready = 1'b0;
    #1;
    chk("wt_next_valid", 64'(b_sub_valid), 64'd1);
    chk("wt_next_gidx", 64'(b_gidx), 64'd1);
    chk("wt_next_wen", 64'(b_sub_wen), 64'd0);
    chk("wt_next_addr", 64'(b_sub_addr), 64'h0000_0300);
    b_sub_ready = 1'b1;
    step();
    b_sub_ready = 1'b0;
    b_valid = 4'b0000;
    #1 chk("wt_idle", 64'(b_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/letc_core_limp_arbiter.md
# letc_core_limp_arbiter

Parametrised N-way arbiter that multiplexes LETC Core LIMP memory requesters (L1 I-cache, L1 D-cache, MMU, and future requesters) onto the single LIMP port of the AXI FSM. It replaces the fixed three-requester arrangement with a configurable requester count, address/data widths and arbitration mode (fixed-priority or round-robin). Grants are registered and held for a whole transaction, and back-to-back grants are issued with no idle cycle.

## Interface
- NUM_REQ, 3, number of requesters (1..16)
- ADDR_W, 32, request address width
- DATA_W, 32, read/write data width
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- IDX_W, $clog2(NUM_REQ) (minimum 1), derived; do not override

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- i_req_wen_nren  in  NUM_REQ  1 = write, 0 = read
- i_req_size  in  2*NUM_REQ  access size per requester (00 byte, 01 half, 10 word)
- i_req_addr  in  ADDR_W*NUM_REQ  packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W]
- i_req_wdata  in  DATA_W*NUM_REQ  packed write data, same packing as i_req_addr
- o_req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester
- o_req_rdata  out  DATA_W  read data, broadcast; meaningful only with o_req_ready
- o_sub_valid  out  1  request valid to the AXI FSM
- o_sub_wen_nren, o_sub_size, o_sub_addr, o_sub_wdata  out  1/2/ADDR_W/DATA_W  muxed request fields
- i_sub_ready  in  1  AXI FSM completion pulse
- i_sub_rdata  in  DATA_W  AXI FSM read data
- o_busy  out  1  a grant is active
- o_grant_idx  out  IDX_W  index of the current or most recent grant

## Operation
- LIMP rules: a requester raises valid with stable fields and holds them until it sees ready. Ready is a single-cycle pulse. The requester may drop valid or present a new request on the cycle after ready.
- State machine has two states.
  - IDLE: o_sub_valid = 0. If any i_req_valid bit is set, the winner is computed combinationally, registered into grant_idx, and the next state is BUSY.
  - BUSY: o_sub_valid = 1 and the o_sub_* fields are muxed live from requester grant_idx. o_req_ready[grant_idx] = i_sub_ready and all other ready bits are 0. o_req_rdata = i_sub_rdata.
- BUSY completion: on a cycle with i_sub_ready = 1, the arbiter re-arbitrates among i_req_valid with bit grant_idx masked.
  - If any masked request exists, it stays in BUSY with the new grant_idx (back-to-back).
  - Otherwise it goes to IDLE.
- Fixed priority (ARB_MODE 0): the lowest set index wins.
- Round-robin (ARB_MODE 1): rr_ptr is updated to (winner+1) mod NUM_REQ at every grant. The search starts at rr_ptr and wraps past NUM_REQ-1 to 0.
- The grant is never changed or revoked mid-transaction, regardless of new higher-priority requests.
- Dropping valid while granted is a protocol violation. The arbiter holds the grant and a simulation assertion fires. Synthesised behaviour stays in BUSY until i_sub_ready.
- NUM_REQ = 1: there is no arbitration logic, but the same IDLE/BUSY timing applies.
- Reset (asynchronous, any state including mid-transaction):
  - state = IDLE, grant_idx = 0, rr_ptr = 0.
  - o_sub_valid = 0, o_req_ready = 0, o_busy = 0, o_grant_idx = 0.
  - o_sub_* data fields are don't-care. The AXI FSM is reset by the same i_rst_n.

## Timing
- Grant latency: a request first seen in IDLE at cycle t produces o_sub_valid = 1 at cycle t+1.
- Completion path: i_sub_ready → o_req_ready and i_sub_rdata → o_req_rdata are combinational, with zero added latency.
- Back-to-back: if completion is at cycle t, the next requester's o_sub_valid is still 1 at t+1 with new fields. There is no bubble.
- Single-requester streaming: a requester re-raising valid right after its own ready at t goes through IDLE. Its next o_sub_valid appears at t+2.
- o_busy equals (state == BUSY) and is registered.
- o_grant_idx is registered and retains its value in IDLE.

## Test plan
- Reset mid-transaction: requester 1 is granted and BUSY, then i_rst_n is pulsed low for 1 cycle → all outputs return to reset values asynchronously. With i_req_valid = 3'b010 still high, the next grant to 1 appears 1 cycle after reset deassertion.
- Simple read, NUM_REQ = 3, ARB_MODE 0: req 2 reads addr 0x8000_0010. i_sub_ready is asserted 3 cycles after o_sub_valid with rdata 0xDEAD_BEEF → o_sub_addr = 0x8000_0010 and o_sub_wen_nren = 0. o_req_ready = 3'b100 for exactly 1 cycle with o_req_rdata = 0xDEAD_BEEF. Then IDLE.
- Fixed priority with no preemption: req 2 is granted, then req 0 raises valid mid-transaction → req 2 completes first. Req 0 is granted the cycle after with no bubble (o_sub_valid stays 1).
- Round-robin fairness, ARB_MODE 1: all 3 requesters hold valid and re-request immediately, with i_sub_ready 1 cycle after each grant → grant sequence is 0,1,2,0,1,2 and each requester gets 2 grants in 6 transactions.
- Round-robin wrap with NUM_REQ = 4: rr_ptr = 3, i_req_valid = 4'b0011 → grant 0 (wrap), then rr_ptr = 1. The next arbitration with 4'b0011 gives grant 1.
- Write path with packed fields, NUM_REQ = 4: req 3 writes wdata 0x1234_5678, size 01, addr 0x0000_0F02 → o_sub_wdata, o_sub_size and o_sub_addr match exactly. A concurrent req 1 is not granted until the cycle after req 3's o_req_ready.
